// File: rtl/snell_pkg.sv
// Shared constants and FSM encoding for the Snell's-law datapath.
// Used by snell_numerator_prep, divide_algo and the downstream arcsine stage.
package snell_pkg;

  localparam int unsigned N_W       = 8;   // refractive index, unsigned Q2.6
  localparam int unsigned SIN_W     = 16;  // sine, unsigned Q1.15
  localparam int unsigned ANG_W     = 7;   // angle, integer degrees
  localparam int unsigned OUT_W     = 16;  // dividend/divider width
  localparam int unsigned SHIFT     = 7;   // Q3.21 product -> 2^14 scale
  localparam int unsigned ANGLE_MAX = 90;
  localparam int unsigned ACC_W     = 24;  // Q3.21 accumulator
  localparam int unsigned BIT_W     = $clog2(N_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MUL    = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/sin_rom.sv
// 91-entry synchronous sine ROM, entry d = round(sin(d deg) * 32768).
// Ports:
//   clk  - rising-edge clock
//   addr - angle in degrees; values above 90 read entry 90
//   data - registered sine, Q1.15, valid one edge after addr
module sin_rom
  import snell_pkg::*;
(
  input  logic             clk,
  input  logic [ANG_W-1:0] addr,
  output logic [SIN_W-1:0] data
);

  localparam int unsigned SIN_TAB [0:ANGLE_MAX] = '{
        0,   572,  1144,  1715,  2286,  2856,  3425,  3993,  4560,  5126,
     5690,  6252,  6813,  7371,  7927,  8481,  9032,  9580, 10126, 10668,
    11207, 11743, 12275, 12803, 13328, 13848, 14365, 14876, 15384, 15886,
    16384, 16877, 17364, 17847, 18324, 18795, 19261, 19720, 20174, 20622,
    21063, 21498, 21926, 22348, 22763, 23170, 23571, 23965, 24351, 24730,
    25102, 25466, 25822, 26170, 26510, 26842, 27166, 27482, 27789, 28088,
    28378, 28660, 28932, 29197, 29452, 29698, 29935, 30163, 30382, 30592,
    30792, 30983, 31164, 31336, 31499, 31651, 31795, 31928, 32052, 32166,
    32270, 32365, 32449, 32524, 32588, 32643, 32688, 32723, 32748, 32763,
    32768
  };

  logic [ANG_W-1:0] idx;
  logic [SIN_W-1:0] data_d;
  logic [SIN_W-1:0] data_q;

  always_comb begin
    idx    = (addr > ANG_W'(ANGLE_MAX)) ? ANG_W'(ANGLE_MAX) : addr;
    data_d = SIN_W'(SIN_TAB[idx]);
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/snell_numerator_prep.sv
// Forms dividend = n1*sin(theta1)*2^14 and divider = n2 for divide_algo,
// so that the quotient is sin(theta2) in Q1.8. Flags total internal
// reflection (tir) and illegal inputs (err).
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   start               - job request, sampled only while idle
//   theta1, n1, n2      - incidence angle (deg), indices (Q2.6)
//   busy                - high whenever a job is in flight or held
//   out_valid/out_ready - result handshake
//   dividend, divider   - operands for divide_algo
//   tir, err            - total internal reflection / bad input flags
module snell_numerator_prep
  import snell_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ANG_W-1:0] theta1,
  input  logic [N_W-1:0]   n1,
  input  logic [N_W-1:0]   n2,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dividend,
  output logic [OUT_W-1:0] divider,
  output logic             tir,
  output logic             err
);

  state_e state_q, state_d;

  logic [ANG_W-1:0] theta_q, theta_d;
  logic [N_W-1:0]   n1_q, n1_d, n2_q, n2_d;
  logic             bad_q, bad_d;
  logic [SIN_W-1:0] sin_q, sin_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [OUT_W-1:0] dividend_q, dividend_d, divider_q, divider_d;
  logic             tir_q, tir_d, err_q, err_d, valid_q, valid_d;

  logic [ANG_W-1:0] rom_addr;
  logic [SIN_W-1:0] rom_data;
  logic             bad_in;
  logic             tir_calc;

  // While idle the ROM reads the live input so its registered output is
  // ready in LOOKUP without an extra cycle.
  assign rom_addr = (state_q == ST_IDLE) ? theta1 : theta_q;

  sin_rom u_sin_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign bad_in   = (theta1 > ANG_W'(ANGLE_MAX)) || (n2 == '0);
  // Both sides at 2^14 scale; equality means theta2 = 90 deg, not TIR.
  assign tir_calc = ACC_W'(acc_q[SHIFT+OUT_W-1:SHIFT]) > ACC_W'({n2_q, 8'h00});

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = bad_in ? ST_DONE : ST_LOOKUP;
      ST_LOOKUP: state_d = ST_MUL;
      ST_MUL:    if (bit_q == BIT_W'(N_W - 1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_HOLD;
      ST_HOLD:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    theta_d    = theta_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    bad_d      = bad_q;
    sin_d      = sin_q;
    acc_d      = acc_q;
    bit_d      = bit_q;
    dividend_d = dividend_q;
    divider_d  = divider_q;
    tir_d      = tir_q;
    err_d      = err_q;
    valid_d    = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          theta_d = theta1;
          n1_d    = n1;
          n2_d    = n2;
          bad_d   = bad_in;
          acc_d   = '0;
          bit_d   = '0;
        end
      end
      ST_LOOKUP: sin_d = rom_data;
      ST_MUL: begin
        if (n1_q[bit_q]) acc_d = acc_q + (ACC_W'(sin_q) << bit_q);
        bit_d = bit_q + BIT_W'(1);
      end
      ST_DONE: begin
        valid_d = 1'b1;
        if (bad_q) begin
          dividend_d = '0;
          divider_d  = OUT_W'(1);
          tir_d      = 1'b0;
          err_d      = 1'b1;
        end else begin
          dividend_d = acc_q[SHIFT+OUT_W-1:SHIFT];
          divider_d  = OUT_W'(n2_q);
          tir_d      = tir_calc;
          err_d      = 1'b0;
        end
      end
      ST_HOLD: if (out_ready) valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      theta_q    <= '0;
      n1_q       <= '0;
      n2_q       <= '0;
      bad_q      <= 1'b0;
      sin_q      <= '0;
      acc_q      <= '0;
      bit_q      <= '0;
      dividend_q <= '0;
      divider_q  <= OUT_W'(1);
      tir_q      <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      theta_q    <= theta_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      bad_q      <= bad_d;
      sin_q      <= sin_d;
      acc_q      <= acc_d;
      bit_q      <= bit_d;
      dividend_q <= dividend_d;
      divider_q  <= divider_d;
      tir_q      <= tir_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign dividend  = dividend_q;
  assign divider   = divider_q;
  assign tir       = tir_q;
  assign err       = err_q;

endmodule

// File: tb/tb_snell_numerator_prep.sv
module tb_snell_numerator_prep;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [6:0]  theta1;
  logic [7:0]  n1, n2;
  logic        busy, out_valid, tir, err;
  logic [15:0] dividend, divider;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  snell_numerator_prep dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .theta1    (theta1),
    .n1        (n1),
    .n2        (n2),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .divider   (divider),
    .tir       (tir),
    .err       (err)
  );

  // Reference: real-valued sine rounded to Q1.15, product scaled to 2^14.
  function automatic void model(input int th, input int a, input int b,
                                output logic [15:0] dvd, output logic [15:0] dvr,
                                output logic t, output logic e);
    real s;
    int  sv, prod;
    if (th > 90 || b == 0) begin
      dvd = 16'd0; dvr = 16'd1; t = 1'b0; e = 1'b1;
    end else begin
      s    = $sin(real'(th) * 3.14159265358979 / 180.0);
      sv   = int'($floor(s * 32768.0 + 0.5));
      prod = (a * sv) / 128;
      dvd  = 16'(prod);
      dvr  = 16'(b);
      t    = (prod > b * 256);
      e    = 1'b0;
    end
  endfunction

  // Launch one job; lat counts the start edge as 1. Optionally scrambles
  // inputs and start while the job is in flight.
  task automatic run_job(input int th, input int a, input int b,
                         input bit scramble, output int lat);
    @(negedge clk);
    theta1 = 7'(th); n1 = 8'(a); n2 = 8'(b); start = 1'b1;
    @(posedge clk); #1;
    lat   = 1;
    start = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (scramble) begin
        theta1 = 7'($urandom); n1 = 8'($urandom); n2 = 8'($urandom);
        start  = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    theta1 = '0; n1 = '0; n2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_valid, dividend, divider, tir, err} !== {1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0})
      $display("FAIL reset_state: got busy=%b vld=%b dvd=%h dvr=%h tir=%b err=%b, want 0 0 0000 0001 0 0",
               busy, out_valid, dividend, divider, tir, err);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    int vec [7][3] = '{'{30, 8'h40, 8'h60}, '{90, 8'h60, 8'h40}, '{90, 8'hFF, 8'h40},
                       '{45, 8'h5A, 8'h40}, '{30, 8'h40, 8'h00}, '{95, 8'h40, 8'h60},
                       '{0, 8'hFF, 8'h01}};
    logic [15:0] e_dvd, e_dvr;
    logic        e_t, e_e;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      model(vec[i][0], vec[i][1], vec[i][2], e_dvd, e_dvr, e_t, e_e);
      run_job(vec[i][0], vec[i][1], vec[i][2], 1'b0, lat);
      checks++;
      if ({dividend, divider, tir, err} !== {e_dvd, e_dvr, e_t, e_e})
        $display("FAIL directed[%0d]_result: got dvd=%h dvr=%h tir=%b err=%b, want dvd=%h dvr=%h tir=%b err=%b",
                 i, dividend, divider, tir, err, e_dvd, e_dvr, e_t, e_e);
      else passed++;
      checks++;
      if (lat !== (e_e ? 2 : 11))
        $display("FAIL directed[%0d]_latency: got %0d edges, want %0d", i, lat, e_e ? 2 : 11);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy} !== 2'b00)
        $display("FAIL directed[%0d]_accept: got vld=%b busy=%b, want 0 0", i, out_valid, busy);
      else passed++;
    end
  endtask

  task automatic test_hold_stall();
    logic [15:0] e_dvd, e_dvr;
    logic        e_t, e_e;
    int          lat;
    bit          bad;
    out_ready = 1'b0;
    model(60, 8'h70, 8'h50, e_dvd, e_dvr, e_t, e_e);
    run_job(60, 8'h70, 8'h50, 1'b0, lat);
    checks++;
    if ({dividend, divider, tir, err} !== {e_dvd, e_dvr, e_t, e_e} || lat !== 11)
      $display("FAIL stall_result: got dvd=%h dvr=%h tir=%b err=%b lat=%0d, want dvd=%h dvr=%h tir=%b err=%b lat=11",
               dividend, divider, tir, err, lat, e_dvd, e_dvr, e_t, e_e);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      theta1 = 7'($urandom); n1 = 8'($urandom); n2 = 8'($urandom); start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy, dividend, divider, tir, err} !== {2'b11, e_dvd, e_dvr, e_t, e_e})
        $display("FAIL stall_hold[%0d]: got vld=%b busy=%b dvd=%h dvr=%h tir=%b err=%b, want 1 1 %h %h %b %b",
                 c, out_valid, busy, dividend, divider, tir, err, e_dvd, e_dvr, e_t, e_e);
      else passed++;
    end
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, dividend, divider, tir, err} !== {2'b00, e_dvd, e_dvr, e_t, e_e})
      $display("FAIL stall_accept: got vld=%b busy=%b dvd=%h dvr=%h tir=%b err=%b, want 0 0 %h %h %b %b",
               out_valid, busy, dividend, divider, tir, err, e_dvd, e_dvr, e_t, e_e);
    else passed++;
    bad = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL stall_no_second_job: got activity after accept, want idle");
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] e_dvd, e_dvr;
    logic        e_t, e_e;
    int          lat;
    bit          bad;
    run_job(30, 8'h40, 8'h60, 1'b0, lat);
    @(posedge clk);
    @(negedge clk);
    theta1 = 7'd60; n1 = 8'h80; n2 = 8'h70; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, out_valid, dividend, divider, tir, err} !== {1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0})
      $display("FAIL midreset_state: got busy=%b vld=%b dvd=%h dvr=%h tir=%b err=%b, want 0 0 0000 0001 0 0",
               busy, out_valid, dividend, divider, tir, err);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL midreset_no_pulse: got activity after reset, want idle");
    else passed++;
    model(60, 8'h80, 8'h70, e_dvd, e_dvr, e_t, e_e);
    run_job(60, 8'h80, 8'h70, 1'b0, lat);
    checks++;
    if ({dividend, divider, tir, err} !== {e_dvd, e_dvr, e_t, e_e} || lat !== 11)
      $display("FAIL midreset_fresh_job: got dvd=%h dvr=%h tir=%b err=%b lat=%0d, want dvd=%h dvr=%h tir=%b err=%b lat=11",
               dividend, divider, tir, err, lat, e_dvd, e_dvr, e_t, e_e);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] e_dvd, e_dvr;
    logic        e_t, e_e;
    int          th, a, b, lat;
    for (int i = 0; i < 40; i++) begin
      th = ($urandom_range(0, 9) == 0) ? $urandom_range(91, 127) : $urandom_range(0, 90);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
      model(th, a, b, e_dvd, e_dvr, e_t, e_e);
      run_job(th, a, b, 1'b1, lat);
      checks++;
      if ({dividend, divider, tir, err} !== {e_dvd, e_dvr, e_t, e_e} || lat !== (e_e ? 2 : 11))
        $display("FAIL random[%0d] th=%0d n1=%h n2=%h: got dvd=%h dvr=%h tir=%b err=%b lat=%0d, want dvd=%h dvr=%h tir=%b err=%b lat=%0d",
                 i, th, a, b, dividend, divider, tir, err, lat, e_dvd, e_dvr, e_t, e_e, e_e ? 2 : 11);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int vec [4][3] = '{'{90, 8'hFF, 8'h40}, '{95, 8'h20, 8'h30}, '{0, 8'h80, 8'h40}, '{30, 8'h40, 8'h60}};
    logic [15:0] e_dvd, e_dvr;
    logic        e_t, e_e;
    int          lat;
    for (int k = 0; k < 4; k++) begin
      model(vec[k][0], vec[k][1], vec[k][2], e_dvd, e_dvr, e_t, e_e);
      @(negedge clk);
      theta1 = 7'(vec[k][0]); n1 = 8'(vec[k][1]); n2 = 8'(vec[k][2]); start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      checks++;
      if (busy !== 1'b1) $display("FAIL b2b[%0d]_launch: got busy=%b, want 1", k, busy);
      else passed++;
      while (out_valid !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if ({dividend, divider, tir, err} !== {e_dvd, e_dvr, e_t, e_e} || lat !== (e_e ? 2 : 11))
        $display("FAIL b2b[%0d]_result: got dvd=%h dvr=%h tir=%b err=%b lat=%0d, want dvd=%h dvr=%h tir=%b err=%b lat=%0d",
                 k, dividend, divider, tir, err, lat, e_dvd, e_dvr, e_t, e_e, e_e ? 2 : 11);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy} !== 2'b00)
        $display("FAIL b2b[%0d]_accept: got vld=%b busy=%b, want 0 0", k, out_valid, busy);
      else passed++;
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
